// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit packed-BCD counter with modulo window [MIN_VALUE, MAX_VALUE], load, optional down-count, wrap pulse.
// Ports: clk; i_rst_n async active-low reset; i_en count enable; i_up direction (1 = up);
//        i_load sync load strobe; i_load_value packed-BCD load value; q registered count; o_wrap registered wrap pulse.
// Define BCD_CNT_DOWN_EN to build decrement/down-wrap logic; otherwise i_up is ignored and the counter is up-only.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] INIT_VALUE = '0,
  parameter logic [4*DIGITS-1:0] MIN_VALUE = '0,
  parameter logic [4*DIGITS-1:0] MAX_VALUE = {DIGITS{4'h9}}
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_value,
  output logic [4*DIGITS-1:0]   q,
  output logic                  o_wrap
);
  localparam int W = 4*DIGITS;
  function automatic logic bcd_ok(input logic [W-1:0] v);
    bcd_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (v[4*i+:4] > 4'd9) bcd_ok = 1'b0;
  endfunction
  if (DIGITS < 1 || DIGITS > 8 || !bcd_ok(INIT_VALUE) || !bcd_ok(MIN_VALUE) || !bcd_ok(MAX_VALUE) ||
      MIN_VALUE > INIT_VALUE || INIT_VALUE > MAX_VALUE) begin : g_bad_params
    $error("bcd_counter_n: illegal parameters");
  end
  logic [W-1:0] cnt_q, cnt_d, inc, clamp;
  logic wrap_q, wrap_d, c;
  // Full ripple carry: a digit rolls 9->0 only while every lower digit is also rolling.
  always_comb begin
    inc = cnt_q;
    clamp = i_load_value;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = c ? (cnt_q[4*i+:4] >= 4'd9 ? 4'd0 : cnt_q[4*i+:4] + 4'd1) : cnt_q[4*i+:4];
      c = c & (cnt_q[4*i+:4] >= 4'd9);
      clamp[4*i+:4] = i_load_value[4*i+:4] > 4'd9 ? 4'd9 : i_load_value[4*i+:4];
    end
  end
`ifdef BCD_CNT_DOWN_EN
  logic [W-1:0] dec;
  logic b;
  always_comb begin
    dec = cnt_q;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dec[4*i+:4] = b ? (cnt_q[4*i+:4] == 4'd0 ? 4'd9 : cnt_q[4*i+:4] - 4'd1) : cnt_q[4*i+:4];
      b = b & (cnt_q[4*i+:4] == 4'd0);
    end
  end
`else
  logic unused_up;
  assign unused_up = i_up;
`endif
  always_comb begin
    cnt_d = cnt_q;
    wrap_d = 1'b0;
    if (i_load) cnt_d = clamp;
    else if (i_en) begin
`ifdef BCD_CNT_DOWN_EN
      if (!i_up) begin
        wrap_d = cnt_q <= MIN_VALUE;
        cnt_d = wrap_d ? MAX_VALUE : dec;
      end else
`endif
      begin
        wrap_d = cnt_q >= MAX_VALUE;
        cnt_d = wrap_d ? MIN_VALUE : inc;
      end
    end
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= INIT_VALUE;
      wrap_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  assign q = cnt_q;
  assign o_wrap = wrap_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: scoreboard bench for bcd_counter_n over three parameterisations.
module tb_bcd_counter_n;
`ifdef BCD_CNT_DOWN_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif
  localparam logic [31:0] MN [3] = '{32'h0, 32'h001, 32'h05};
  localparam logic [31:0] MX [3] = '{32'h9999, 32'h100, 32'h59};
  localparam logic [31:0] IV [3] = '{32'h0, 32'h098, 32'h05};
  typedef struct { logic [31:0] q; logic w; } exp_t;
  exp_t sb [$];
  logic [31:0] cur [3];
  logic clk = 1'b0, rst_n = 1'b1;
  logic [2:0] en = '0, up = '0, ld = '0, w;
  logic [31:0] lv [3];
  logic [15:0] q0;
  logic [11:0] q1;
  logic [7:0] q2;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  bcd_counter_n u0 (.clk(clk), .i_rst_n(rst_n), .i_en(en[0]), .i_up(up[0]), .i_load(ld[0]),
                    .i_load_value(lv[0][15:0]), .q(q0), .o_wrap(w[0]));
  bcd_counter_n #(.DIGITS(3), .INIT_VALUE(12'h098), .MIN_VALUE(12'h001), .MAX_VALUE(12'h100)) u1 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en[1]), .i_up(up[1]), .i_load(ld[1]),
    .i_load_value(lv[1][11:0]), .q(q1), .o_wrap(w[1]));
  bcd_counter_n #(.DIGITS(2), .INIT_VALUE(8'h05), .MIN_VALUE(8'h05), .MAX_VALUE(8'h59)) u2 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en[2]), .i_up(up[2]), .i_load(ld[2]),
    .i_load_value(lv[2][7:0]), .q(q2), .o_wrap(w[2]));
  function automatic int b2i(input logic [31:0] v);
    int r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction
  function automatic logic [31:0] i2b(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction
  function automatic logic [32:0] act(input int k);
    return k == 0 ? {w[0], 16'h0, q0} : k == 1 ? {w[1], 20'h0, q1} : {w[2], 24'h0, q2};
  endfunction
  task automatic drive(input int k, input bit e, input bit u, input bit l, input logic [31:0] v);
    exp_t x;
    @(negedge clk);
    en = '0;
    ld = '0;
    en[k] = e;
    up[k] = u;
    ld[k] = l;
    lv[k] = v;
    x.q = cur[k];
    x.w = 1'b0;
    if (l) for (int i = 0; i < 8; i++) x.q[4*i+:4] = v[4*i+:4] > 4'd9 ? 4'd9 : v[4*i+:4];
    else if (e && (u || !DOWN)) begin
      x.w = cur[k] >= MX[k];
      x.q = x.w ? MN[k] : i2b(b2i(cur[k]) + 1);
    end else if (e) begin
      x.w = cur[k] <= MN[k];
      x.q = x.w ? MX[k] : i2b(b2i(cur[k]) - 1);
    end
    sb.push_back(x);
    cur[k] = x.q;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic [32:0] a;
    #2 rst_n = 1'b0;
    #10;
    for (int k = 0; k < 3; k++) begin
      cur[k] = IV[k];
      a = act(k);
      n_chk++;
      if (a[31:0] !== IV[k] || a[32] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got q=%h wrap=%b, expected q=%h wrap=0", k, a[31:0], a[32], IV[k]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_full_count;
    exp_t x;
    logic [32:0] a;
    for (int n = 0; n < 10000; n++) begin
      drive(0, 1, 1, 0, 0);
      x = sb.pop_front();
      a = act(0);
      n_chk++;
      if (a[31:0] !== x.q || a[32] !== x.w) begin
        n_fail++;
        $display("FAIL full_count step %0d: got q=%h wrap=%b, expected q=%h wrap=%b", n, a[31:0], a[32], x.q, x.w);
      end
    end
  endtask
  task automatic test_async_reset;
    exp_t x;
    logic [32:0] a;
    drive(0, 0, 1, 1, 32'h0450);
    for (int n = 0; n < 7; n++) drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    for (int n = 0; n < 9; n++) begin
      x = sb.pop_front();
      if (n == 8) begin
        a = act(0);
        n_chk++;
        if (a[31:0] !== x.q) begin
          n_fail++;
          $display("FAIL pre_reset: got q=%h, expected q=%h", a[31:0], x.q);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      cur[k] = IV[k];
      a = act(k);
      n_chk++;
      if (a[31:0] !== IV[k] || a[32] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got q=%h wrap=%b, expected q=%h wrap=0", k, a[31:0], a[32], IV[k]);
      end
    end
    cur[2] = IV[2];
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 1, 0, 0);
      x = sb.pop_front();
      a = act(0);
      n_chk++;
      if (a[31:0] !== x.q || a[32] !== x.w) begin
        n_fail++;
        $display("FAIL hold_after_reset: got q=%h wrap=%b, expected q=%h wrap=%b", a[31:0], a[32], x.q, x.w);
      end
    end
  endtask
  task automatic test_load_clamp;
    exp_t x;
    logic [32:0] a;
    drive(0, 1, 1, 1, 32'h1A3F);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      x = sb.pop_front();
      n_chk++;
      if (n == 0 && x.q !== 32'h1939) begin
        n_fail++;
        $display("FAIL load_clamp_model: got q=%h, expected q=00001939", x.q);
      end
    end
    a = act(0);
    n_chk++;
    if (a[31:0] !== 32'h1940 || a[32] !== 1'b0) begin
      n_fail++;
      $display("FAIL load_then_step: got q=%h wrap=%b, expected q=00001940 wrap=0", a[31:0], a[32]);
    end
  endtask
  task automatic test_load_seq;
    exp_t x;
    logic [32:0] a;
    drive(0, 1, 1, 1, 32'h1A3F);
    x = sb.pop_front();
    a = act(0);
    n_chk++;
    if (a[31:0] !== x.q || a[32] !== x.w) begin
      n_fail++;
      $display("FAIL load_1A3F: got q=%h wrap=%b, expected q=%h wrap=%b", a[31:0], a[32], x.q, x.w);
    end
  endtask
  task automatic test_window;
    exp_t x;
    logic [32:0] a;
    for (int n = 0; n < 6; n++) begin
      if (n < 4) drive(1, 1, 1, 0, 0);
      else if (n == 4) drive(1, 0, 1, 1, 32'h250);
      else drive(1, 1, 1, 0, 0);
      x = sb.pop_front();
      a = act(1);
      n_chk++;
      if (a[31:0] !== x.q || a[32] !== x.w) begin
        n_fail++;
        $display("FAIL window step %0d: got q=%h wrap=%b, expected q=%h wrap=%b", n, a[31:0], a[32], x.q, x.w);
      end
    end
  endtask
  task automatic test_down;
    exp_t x;
    logic [32:0] a;
    drive(2, 0, 0, 1, DOWN ? 32'h10 : 32'h58);
    for (int n = 0; n < (DOWN ? 7 : 3); n++) begin
      if (n > 0) drive(2, 1, n == 6, 0, 0);
      else if (!DOWN) drive(2, 1, 1, 0, 0);
      else drive(2, 1, 0, 0, 0);
      if (n == 0) void'(sb.pop_front());
      x = sb.pop_front();
      a = act(2);
      n_chk++;
      if (a[31:0] !== x.q || a[32] !== x.w) begin
        n_fail++;
        $display("FAIL window2 step %0d: got q=%h wrap=%b, expected q=%h wrap=%b", n, a[31:0], a[32], x.q, x.w);
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      cur[k] = IV[k];
      lv[k] = '0;
    end
    test_reset;
    test_full_count;
    test_async_reset;
    test_load_seq;
    test_load_clamp;
    test_window;
    test_down;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
